stream_demux: RTL and testbench
===============================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter N_SLAVES, default 4: number of output ports; legal range 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 4: bits per transfer.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port s_valid, input, 1: upstream transfer offered.
REQ-006 SHALL have port s_ready, output, 1: block accepts the offered transfer this cycle.
REQ-007 SHALL have port s_sel, input, $clog2(N_SLAVES): destination index.
REQ-008 SHALL have port s_data, input, DATA_WIDTH: payload.
REQ-009 SHALL have port m_valid, output, N_SLAVES: bit i means slot i holds data.
REQ-010 SHALL have port m_ready, input, N_SLAVES: bit i means consumer i takes slot i.
REQ-011 SHALL have port m_data, output, DATA_WIDTH*N_SLAVES: packed; slot i at [DATA_WIDTH*i +: DATA_WIDTH], the same packing the team's mux uses on its data input.

Function
REQ-012 SHALL hold one registered slot per output, each with valid flag and data register.
REQ-013 SHALL complete an upstream transfer when s_valid && s_ready are high at a rising edge.
REQ-014 SHALL compute s_ready combinationally: for in-range s_sel, s_ready = !m_valid[s_sel] || m_ready[s_sel]; s_ready SHALL NOT depend on s_valid.
REQ-015 SHALL present an accepted payload on m_data slot s_sel with m_valid[s_sel]=1 on the cycle after acceptance (latency 1).
REQ-016 SHALL keep m_data slot i and m_valid[i] stable while m_valid[i]=1 and m_ready[i]=0.
REQ-017 SHALL clear m_valid[i] when m_valid[i] && m_ready[i] and slot i is not reloaded in the same cycle.
REQ-018 SHALL treat a simultaneous drain and reload of slot i as a pass-through: m_valid[i] stays 1 and the data register takes the new payload, with no bubble.
REQ-019 SHALL update slots independently; draining slot j SHALL NOT affect slot i.
REQ-020 SHALL leave the data register unchanged when a slot is not loaded; m_data content with m_valid[i]=0 is don't-care but deterministic.
REQ-021 SHALL, for out-of-range s_sel (s_sel >= N_SLAVES, possible only for non-power-of-two N_SLAVES), drive s_ready=1 and discard the transfer without changing any slot.

Reset
REQ-022 SHALL, while rst=1, force m_valid to all 0 and every slot data register to 0 asynchronously.
REQ-023 SHALL discard slot contents on a reset asserted mid-transfer, with no partial delivery after deassertion.
REQ-024 SHALL resume normal operation on the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL support macro STREAM_DEMUX_DROP_CNT_EN.
REQ-026 With STREAM_DEMUX_DROP_CNT_EN defined, SHALL add port drop_cnt, output, 8: count of discarded out-of-range transfers; reset to 0; increments by 1 per discard; saturates at 255.
REQ-027 Without STREAM_DEMUX_DROP_CNT_EN, port drop_cnt and its logic SHALL be absent; out-of-range handling is otherwise identical.

Structure
REQ-028 SHALL place the following in the team's shared mux/demux package/header: select width SEL_W = $clog2(N_SLAVES) and the slice-offset convention DATA_WIDTH*i.
REQ-029 SHALL instantiate one sub-module, demux_slot, per output (generate loop); each has a load/drain one-entry register with valid flag.
REQ-030 SHALL keep the s_ready decode and the drop counter in the top level.

Verification (N_SLAVES=4, DATA_WIDTH=4 unless stated)
REQ-031 Reset check: assert rst mid-cycle with slot 2 full -> m_valid=4'b0000 and m_data=16'h0000 immediately, without waiting for clk.
REQ-032 Single route: s_sel=1, s_data=4'hA, m_ready=4'b1111, one accept -> next cycle m_valid=4'b0010 and m_data[7:4]=4'hA; following cycle m_valid=4'b0000.
REQ-033 Backpressure: m_ready[3]=0, send 4'h5 then 4'h6 to sel 3 -> s_ready=0 on the second offer and slot 3 holds 4'h5; raise m_ready[3] -> 4'h6 accepted that edge and appears next cycle, no bubble.
REQ-034 Independence: slot 0 stalled with 4'h1 while transfers 4'h2 and 4'h3 go to sel 2 -> both delivered in order on slot 2; slot 0 is unchanged throughout.
REQ-035 Sweep (mirrors the team's mux test): sel 0..3 with $random data, m_ready=all 1, loop through the team's mux with the same sel delayed one cycle -> mux op equals the sent data on every cycle.
REQ-036 Out-of-range with N_SLAVES=3 and STREAM_DEMUX_DROP_CNT_EN defined: 300 offers with s_sel=3 -> s_ready=1 throughout, m_valid=3'b000, drop_cnt=255.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared mux/demux helpers: select width and packed-slice offset for per-port data lanes.
package stream_demux_pkg;

  // Select width for a port count; a single port still needs a one-bit select.
  function automatic int unsigned sel_width(input int unsigned n_ports);
    return (n_ports <= 1) ? 1 : $clog2(n_ports);
  endfunction

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return width * idx;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// demux_slot: one-entry output register with valid flag; load and drain may coincide.
module demux_slot #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  drain,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Simultaneous drain and load keeps valid high: pass-through without a bubble.
  always_comb begin
    valid_d = load | (valid_q & ~drain);
    data_d  = load ? load_data : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/stream_demux.sv
// stream_demux: routes one upstream stream to N_SLAVES registered output slots by s_sel.
// Optional out-of-range drop counter enabled with macro STREAM_DEMUX_DROP_CNT_EN.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned N_SLAVES   = 4,
  parameter int unsigned DATA_WIDTH = 4,
  localparam int unsigned SEL_W     = sel_width(N_SLAVES)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [SEL_W-1:0]                 s_sel,
  input  logic [DATA_WIDTH-1:0]            s_data,
  output logic [N_SLAVES-1:0]              m_valid,
  input  logic [N_SLAVES-1:0]              m_ready,
  output logic [DATA_WIDTH*N_SLAVES-1:0]   m_data
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]                       drop_cnt
`endif
);

  logic [N_SLAVES-1:0] load;

  // Out-of-range selects match no slot, so s_ready keeps its default of 1 and nothing loads.
  always_comb begin
    s_ready = 1'b1;
    load    = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (s_sel == SEL_W'(i)) begin
        s_ready = !m_valid[i] || m_ready[i];
        load[i] = s_valid && (!m_valid[i] || m_ready[i]);
      end
    end
  end

  for (genvar g = 0; g < N_SLAVES; g++) begin : g_slot
    localparam int unsigned Lo = slice_lo(g, DATA_WIDTH);

    demux_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[g]),
      .drain     (m_ready[g]),
      .load_data (s_data),
      .valid     (m_valid[g]),
      .data      (m_data[Lo +: DATA_WIDTH])
    );
  end

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic       in_range;
  logic       drop;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    in_range = 1'b0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (s_sel == SEL_W'(i)) begin
        in_range = 1'b1;
      end
    end
    drop       = s_valid && !in_range;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hff)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed scenarios plus random traffic against a per-slot buffer model.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst;

  logic        s_valid;
  logic        s_ready;
  logic [1:0]  s_sel;
  logic [3:0]  s_data;
  logic [3:0]  m_valid;
  logic [3:0]  m_ready;
  logic [15:0] m_data;

  logic        s3_valid;
  logic        s3_ready;
  logic [1:0]  s3_sel;
  logic [3:0]  s3_data;
  logic [2:0]  m3_valid;
  logic [2:0]  m3_ready;
  logic [11:0] m3_data;
`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [7:0]  drop3;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model: each output is a one-entry buffer holding its last loaded payload.
  bit       exp_valid [4];
  bit [3:0] exp_data  [4];

  always #5 clk = ~clk;

  stream_demux #(
    .N_SLAVES   (4),
    .DATA_WIDTH (4)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_sel   (s_sel),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  stream_demux #(
    .N_SLAVES   (3),
    .DATA_WIDTH (4)
  ) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s3_valid),
    .s_ready  (s3_ready),
    .s_sel    (s3_sel),
    .s_data   (s3_data),
    .m_valid  (m3_valid),
    .m_ready  (m3_ready),
    .m_data   (m3_data)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    .drop_cnt (drop3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] model_mvalid();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = exp_valid[i];
    return r;
  endfunction

  function automatic logic [15:0] model_mdata();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = exp_data[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      exp_valid[i] = 1'b0;
      exp_data[i]  = 4'h0;
    end
  endtask

  // Called at posedge+1; drives one cycle of stimulus and checks ready, then outputs after the edge.
  task automatic drive(input logic v, input logic [1:0] sel, input logic [3:0] d,
                       input logic [3:0] mr);
    bit exp_rdy;
    s_valid = v;
    s_sel   = sel;
    s_data  = d;
    m_ready = mr;
    #4;
    exp_rdy = !exp_valid[sel] || mr[sel];
    check("s_ready", {31'd0, s_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (exp_valid[i] && mr[i]) exp_valid[i] = 1'b0;
    end
    if (v && exp_rdy) begin
      exp_valid[sel] = 1'b1;
      exp_data[sel]  = d;
    end
    #1;
    check("m_valid", {28'd0, m_valid}, {28'd0, model_mvalid()});
    check("m_data", {16'd0, m_data}, {16'd0, model_mdata()});
  endtask

  initial begin
    int offers;
    logic [3:0] d;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_sel    = 2'd0;
    s_data   = 4'h0;
    m_ready  = 4'h0;
    s3_valid = 1'b0;
    s3_sel   = 2'd0;
    s3_data  = 4'h0;
    m3_ready = 3'b111;
    model_reset();
    #1;
    check("reset_m_valid", {28'd0, m_valid}, 32'd0);
    check("reset_m_data", {16'd0, m_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single route to slot 1, then drained.
    drive(1'b1, 2'd1, 4'hA, 4'b1111);
    check("route_slot1", {28'd0, m_data[7:4]}, 32'hA);
    drive(1'b0, 2'd1, 4'h0, 4'b1111);
    check("route_drained", {28'd0, m_valid}, 32'd0);

    // Backpressure on slot 3, then pass-through on release.
    drive(1'b1, 2'd3, 4'h5, 4'b0111);
    drive(1'b1, 2'd3, 4'h6, 4'b0111);
    check("bp_hold", {28'd0, m_data[15:12]}, 32'h5);
    drive(1'b1, 2'd3, 4'h6, 4'b1111);
    check("bp_pass", {28'd0, m_data[15:12]}, 32'h6);
    drive(1'b0, 2'd3, 4'h0, 4'b1111);

    // Slot 0 stalled while slot 2 streams.
    drive(1'b1, 2'd0, 4'h1, 4'b1110);
    drive(1'b1, 2'd2, 4'h2, 4'b1110);
    check("indep_s2_first", {28'd0, m_data[11:8]}, 32'h2);
    drive(1'b1, 2'd2, 4'h3, 4'b1110);
    check("indep_s2_second", {28'd0, m_data[11:8]}, 32'h3);
    drive(1'b0, 2'd2, 4'h0, 4'b1110);
    check("indep_s0_held", {28'd0, m_data[3:0]}, 32'h1);
    drive(1'b0, 2'd0, 4'h0, 4'b1111);

    // Asynchronous reset mid-cycle with slot 2 full.
    drive(1'b1, 2'd2, 4'h9, 4'b1011);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_m_valid", {28'd0, m_valid}, 32'd0);
    check("async_rst_m_data", {16'd0, m_data}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 2'd2, 4'h0, 4'b1111);

    // Sweep: loop back through a behavioural mux keyed by the previous cycle's select.
    for (int k = 0; k < 8; k++) begin
      d = 4'($urandom);
      drive(1'b1, 2'(k % 4), d, 4'b1111);
      check("sweep_mux", {28'd0, m_data[4*(k%4) +: 4]}, {28'd0, d});
    end

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 4'($urandom));
    end

    // Out-of-range select on the three-port instance.
    s_valid  = 1'b0;
    s3_valid = 1'b1;
    s3_sel   = 2'd3;
    m3_ready = 3'b111;
    offers   = 0;
    for (int k = 0; k < 300; k++) begin
      s3_data = 4'($urandom);
      #4;
      check("oor_s_ready", {31'd0, s3_ready}, 32'd1);
      @(posedge clk);
      offers++;
      #1;
      check("oor_m_valid", {29'd0, m3_valid}, 32'd0);
      check("oor_m_data", {20'd0, m3_data}, 32'd0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
      check("oor_drop_cnt", {24'd0, drop3}, (offers > 255) ? 32'd255 : 32'(offers));
`endif
    end
    s3_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
